controller_poll_sequencer: RTL and testbench
============================================

# controller_poll_sequencer

Sequences the serial game-controller interface: on a poll request it drives `controller_latch` and `controller_clk` to two shift-register controllers, samples both active-low serial data lines, and updates the CPU-visible button registers `controller_1_buttons_out` / `controller_2_buttons_out`. It sits in the top level next to the controller address decode and runs on the CPU clock. The vblank interrupt logic normally triggers it once per frame.

## Interface
Parameters:
- `LATCH_CYCLES`, default 12: clock cycles `controller_latch` is held high. Must be ≥ 1.
- `HALF_CYCLES`, default 6: clock cycles per half period of `controller_clk`. Must be ≥ 1.

Ports:
- `clk_1` input 1: CPU clock (1 MHz). All logic is on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: poll request. Sampled only in IDLE.
- `controller_1_data_in_B` input 1: controller 1 serial data, active-low (0 = pressed).
- `controller_2_data_in_B` input 1: controller 2 serial data, active-low.
- `controller_clk` output 1: shift clock to both controllers. Idle low.
- `controller_latch` output 1: parallel-load strobe to both controllers.
- `controller_1_buttons_out` output 8: controller 1 buttons, active-high (1 = pressed).
- `controller_2_buttons_out` output 8: controller 2 buttons, active-high.
- `busy` output 1: high from the LATCH state through the COMMIT state, inclusive.
- `done` output 1: one-cycle pulse when new button values become visible.

## Operation
- FSM states: IDLE → LATCH → LOW → HIGH → (LOW … ) → COMMIT → IDLE.
- IDLE: latch = 0, clk = 0, busy = 0. When `start` = 1, go to LATCH; the phase counter loads `LATCH_CYCLES-1` and the bit counter loads 0.
- LATCH: latch = 1 for `LATCH_CYCLES` cycles, then go to LOW.
- LOW: clk = 0 for `HALF_CYCLES` cycles. On the last LOW cycle, sample both data lines into shift registers, MSB first: the first sampled bit ends up in bit 7.
- HIGH: clk = 1 for `HALF_CYCLES` cycles; the controller shifts on this rising edge. After HIGH, if the bit counter = 7 go to COMMIT, else increment the bit counter and go to LOW.
- COMMIT: one cycle. `buttons_out <= ~shift` for both controllers, then go to IDLE.
- `start` while not in IDLE is ignored, not queued. `start` held high starts back-to-back polls, one cycle apart.
- Counter widths:
  - Phase counter is `$clog2(max(LATCH_CYCLES,HALF_CYCLES))` bits, minimum 1, and counts down to 0.
  - Bit counter is 3 bits and wraps only via the FSM.
- `buttons_out` holds its value between polls and never shows partial shift data.

## Timing
- Reset values (asynchronous): state = IDLE, `controller_clk` = 0, `controller_latch` = 0, both `buttons_out` = 8'h00, `busy` = 0, `done` = 0, all shift registers and counters = 0.
- `start` high at edge N: latch = 1 and busy = 1 from edge N+1.
- Poll length = `LATCH_CYCLES + 16*HALF_CYCLES + 1` cycles; 109 cycles with default parameters.
- New `buttons_out` and `done` = 1 both appear on the edge that leaves COMMIT; busy = 0 in that same cycle.
- Outputs are all registered: no combinational path from inputs to outputs.
- Reset asserted mid-poll: all outputs return to their reset values immediately; the interrupted poll is discarded.

## Configuration
- `CONTROLLER_POLL_DEBOUNCE_EN`
  - Defined: each controller keeps the previous poll's raw sample. In COMMIT, `buttons_out` updates only for a controller whose new sample equals its previous sample; otherwise that controller's output holds. `done` still pulses.
  - Undefined: every COMMIT updates both outputs unconditionally. No previous-sample registers exist.

## Structure
- Package `controller_poll_pkg`: FSM state enum, `CONTROLLER_BUTTONS_W = 8`, and the default `LATCH_CYCLES` / `HALF_CYCLES` constants.
- Sub-module `controller_capture_m`, instantiated once per controller, contains:
  - the 8-bit shift register,
  - the optional debounce compare register,
  - the output register.
- Inputs to `controller_capture_m`: sample strobe, commit strobe, data_in_B.
- The FSM and counters stay in the top-level sequencer module.

## Test plan
- Reset release, no start → all outputs 0 indefinitely; latch and clk never toggle.
- Controller 1 buttons 8'b10001001, controller 2 buttons 8'b00100110, one start pulse → latch high for 12 cycles, 8 clk pulses each 6 high / 6 low, `done` at cycle 109, outputs 8'h89 and 8'h26.
- Buttons changed to 8'hFF / 8'h00 and `start` pulsed repeatedly while busy → the extra pulses are ignored. The next accepted poll yields 8'hFF / 8'h00.
- `rst` asserted during the 4th HIGH phase → outputs 0 immediately; after release, the next poll completes normally with correct values.
- With `CONTROLLER_POLL_DEBOUNCE_EN`, controller 1 buttons alternate between 8'h01 and 8'h02 across polls → output stays at the last stable value. A steady 8'h02 over two polls → output 8'h02.
- `start` held high → polls run back-to-back with one IDLE cycle between them; `done` pulses every 110 cycles.

Source files
------------

// File: rtl/controller_poll_sequencer_pkg.sv
// Shared types and constants for the controller poll sequencer.
package controller_poll_pkg;

  localparam int CONTROLLER_BUTTONS_W = 8;
  localparam int DEFAULT_LATCH_CYCLES = 12;
  localparam int DEFAULT_HALF_CYCLES  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_COMMIT
  } poll_state_e;

  // Phase counter width: enough for the longer of the two phases, never zero.
  function automatic int phase_cnt_w(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/controller_poll_sequencer_if.sv
// Serial link between the poll sequencer and the two shift-register controllers.
interface controller_poll_sequencer_if;
  logic latch;
  logic ctrl_clk;
  logic data1_B;
  logic data2_B;

  modport master (output latch, output ctrl_clk, input data1_B, input data2_B);
  modport slave  (input latch, input ctrl_clk, output data1_B, output data2_B);
endinterface

// File: rtl/controller_poll_sequencer_capture.sv
// Per-controller capture: shift register, optional debounce compare, output register.
// Optional feature macro: CONTROLLER_POLL_DEBOUNCE_EN.
module controller_capture_m
  import controller_poll_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            sample_i,
  input  logic                            commit_i,
  input  logic                            data_in_B_i,
  output logic [CONTROLLER_BUTTONS_W-1:0] buttons_o
);

  logic [CONTROLLER_BUTTONS_W-1:0] shift_q, shift_d;
  logic [CONTROLLER_BUTTONS_W-1:0] out_q, out_d;
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
  logic [CONTROLLER_BUTTONS_W-1:0] prev_q, prev_d;
`endif

  always_comb begin
    shift_d = shift_q;
    out_d   = out_q;
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
    prev_d  = prev_q;
`endif
    if (sample_i) begin
      shift_d = {shift_q[CONTROLLER_BUTTONS_W-2:0], data_in_B_i};
    end
    if (commit_i) begin
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
      // Raw samples are compared, so two identical polls are needed to move the output.
      if (shift_q == prev_q) begin
        out_d = ~shift_q;
      end
      prev_d = shift_q;
`else
      out_d = ~shift_q;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      out_q   <= '0;
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
      prev_q  <= '0;
`endif
    end else begin
      shift_q <= shift_d;
      out_q   <= out_d;
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
      prev_q  <= prev_d;
`endif
    end
  end

  assign buttons_o = out_q;

endmodule

// File: rtl/controller_poll_sequencer.sv
// Latches and clocks two serial game controllers and publishes their button state.
// Optional feature macro: CONTROLLER_POLL_DEBOUNCE_EN (handled in controller_capture_m).
module controller_poll_sequencer
  import controller_poll_pkg::*;
#(
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  parameter int HALF_CYCLES  = DEFAULT_HALF_CYCLES
) (
  input  logic                            clk_1,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            controller_1_data_in_B,
  input  logic                            controller_2_data_in_B,
  output logic                            controller_clk,
  output logic                            controller_latch,
  output logic [CONTROLLER_BUTTONS_W-1:0] controller_1_buttons_out,
  output logic [CONTROLLER_BUTTONS_W-1:0] controller_2_buttons_out,
  output logic                            busy,
  output logic                            done
);

  localparam int PW = phase_cnt_w(LATCH_CYCLES, HALF_CYCLES);
  localparam logic [PW-1:0] LATCH_LOAD = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LOAD  = PW'(HALF_CYCLES - 1);

  poll_state_e   state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic          latch_q, latch_d;
  logic          cclk_q, cclk_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sample;
  logic          commit;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sample  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LATCH;
          phase_d = LATCH_LOAD;
          bit_d   = '0;
        end
      end
      ST_LATCH: begin
        if (phase_q == '0) begin
          state_d = ST_LOW;
          phase_d = HALF_LOAD;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      ST_LOW: begin
        if (phase_q == '0) begin
          sample  = 1'b1;
          state_d = ST_HIGH;
          phase_d = HALF_LOAD;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_q == '0) begin
          phase_d = HALF_LOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_COMMIT;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = ST_LOW;
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    latch_d = (state_d == ST_LATCH);
    cclk_d  = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_COMMIT);
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      latch_q <= 1'b0;
      cclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      latch_q <= latch_d;
      cclk_q  <= cclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  controller_capture_m u_cap1 (
    .clk_i       (clk_1),
    .rst_i       (rst),
    .sample_i    (sample),
    .commit_i    (commit),
    .data_in_B_i (controller_1_data_in_B),
    .buttons_o   (controller_1_buttons_out)
  );

  controller_capture_m u_cap2 (
    .clk_i       (clk_1),
    .rst_i       (rst),
    .sample_i    (sample),
    .commit_i    (commit),
    .data_in_B_i (controller_2_data_in_B),
    .buttons_o   (controller_2_buttons_out)
  );

  assign controller_latch = latch_q;
  assign controller_clk   = cclk_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_controller_poll_sequencer.sv
// Directed bench for controller_poll_sequencer with a behavioural pair of serial controllers.
module tb_controller_poll_sequencer;
  import controller_poll_pkg::*;

  logic       clk_1 = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [7:0] b1, b2;
  logic       busy, done;

  logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
  logic [7:0] m1 = 8'hFF, m2 = 8'hFF;
  logic       cclk_prev = 1'b0;

  logic [7:0] e1, e2, p1, p2;
  int checks = 0;
  int errors = 0;

  controller_poll_sequencer_if cif ();

  assign cif.data1_B = m1[7];
  assign cif.data2_B = m2[7];

  controller_poll_sequencer #(.LATCH_CYCLES(12), .HALF_CYCLES(6)) dut (
    .clk_1                    (clk_1),
    .rst                      (rst),
    .start                    (start),
    .controller_1_data_in_B   (cif.data1_B),
    .controller_2_data_in_B   (cif.data2_B),
    .controller_clk           (cif.ctrl_clk),
    .controller_latch         (cif.latch),
    .controller_1_buttons_out (b1),
    .controller_2_buttons_out (b2),
    .busy                     (busy),
    .done                     (done)
  );

  always #5 clk_1 = ~clk_1;

  // Controller model: parallel load while latch is high, shift on each controller_clk rise.
  always @(posedge clk_1) begin
    cclk_prev <= cif.ctrl_clk;
    if (cif.latch) begin
      m1 <= ~btn1;
      m2 <= ~btn2;
    end else if (cif.ctrl_clk && !cclk_prev) begin
      m1 <= {m1[6:0], 1'b1};
      m2 <= {m2[6:0], 1'b1};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e1 = 8'h00; e2 = 8'h00; p1 = 8'h00; p2 = 8'h00;
  endtask

  task automatic model_commit();
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
    if (~btn1 == p1) e1 = btn1;
    if (~btn2 == p2) e2 = btn2;
    p1 = ~btn1;
    p2 = ~btn2;
`else
    e1 = btn1;
    e2 = btn2;
`endif
  endtask

  // One poll from a single start pulse; optionally pulses start again while busy.
  task automatic run_poll(input string pfx, input bit extra);
    int cyc, lat_n, hi_n, rise_n;
    logic prev;
    @(negedge clk_1) start = 1'b1;
    @(negedge clk_1) start = 1'b0;
    check({pfx, "_latch_first"}, cif.latch, 1'b1);
    check({pfx, "_busy_first"}, busy, 1'b1);
    cyc = 1; lat_n = 0; hi_n = 0; rise_n = 0; prev = 1'b0;
    while (!done && cyc < 300) begin
      lat_n += int'(cif.latch);
      hi_n  += int'(cif.ctrl_clk);
      if (cif.ctrl_clk && !prev) rise_n++;
      prev = cif.ctrl_clk;
      start = extra && (cyc == 30 || cyc == 60 || cyc == 109);
      @(negedge clk_1);
      cyc++;
    end
    start = 1'b0;
    if (done) model_commit();
    check({pfx, "_done_cycle"}, cyc, 110);
    check({pfx, "_latch_cycles"}, lat_n, 12);
    check({pfx, "_clk_high_cycles"}, hi_n, 48);
    check({pfx, "_clk_pulses"}, rise_n, 8);
    check({pfx, "_busy_at_done"}, busy, 1'b0);
    check({pfx, "_b1"}, b1, e1);
    check({pfx, "_b2"}, b2, e2);
    @(negedge clk_1);
    check({pfx, "_done_one_cycle"}, done, 1'b0);
    repeat (3) @(negedge clk_1);
    check({pfx, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int act, n;
    model_reset();
    #1;
    check("reset_b1", b1, 8'h00);
    check("reset_b2", b2, 8'h00);
    check("reset_outs", {cif.latch, cif.ctrl_clk, busy, done}, 4'b0000);
    repeat (2) @(negedge clk_1);
    rst = 1'b0;

    // No start: nothing may move.
    act = 0;
    repeat (20) begin
      @(negedge clk_1);
      if (cif.latch || cif.ctrl_clk || busy || done || b1 != 8'h00 || b2 != 8'h00) act++;
    end
    check("idle_quiet", act, 0);

    btn1 = 8'b1000_1001; btn2 = 8'b0010_0110;
    run_poll("poll1", 1'b0);
`ifndef CONTROLLER_POLL_DEBOUNCE_EN
    check("poll1_b1_const", b1, 8'h89);
    check("poll1_b2_const", b2, 8'h26);
`endif

    btn1 = 8'hFF; btn2 = 8'h00;
    run_poll("poll2_extra_starts", 1'b1);
`ifndef CONTROLLER_POLL_DEBOUNCE_EN
    check("poll2_b1_const", b1, 8'hFF);
    check("poll2_b2_const", b2, 8'h00);
`endif

    // Reset in the 4th HIGH phase.
    btn1 = 8'h5A; btn2 = 8'hA5;
    @(negedge clk_1) start = 1'b1;
    @(negedge clk_1) start = 1'b0;
    repeat (56) @(negedge clk_1);
    check("rst_mid_in_high", cif.ctrl_clk, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid_b1", b1, 8'h00);
    check("rst_mid_b2", b2, 8'h00);
    check("rst_mid_outs", {cif.latch, cif.ctrl_clk, busy, done}, 4'b0000);
    @(negedge clk_1) rst = 1'b0;
    repeat (2) @(negedge clk_1);
    run_poll("poll_after_rst", 1'b0);

    // Held start: back-to-back polls.
    btn1 = 8'h3C; btn2 = 8'hC3;
    @(negedge clk_1) start = 1'b1;
    n = 0;
    while (!done && n < 300) begin @(negedge clk_1); n++; end
    check("b2b_first_done_seen", done, 1'b1);
    model_commit();
    n = 0;
    @(negedge clk_1);
    n++;
    while (!done && n < 300) begin @(negedge clk_1); n++; end
    start = 1'b0;
    model_commit();
    check("b2b_done_period", n, 110);
    check("b2b_b1", b1, e1);
    check("b2b_b2", b2, e2);
    repeat (4) @(negedge clk_1);
    check("b2b_stops", busy, 1'b0);

`ifdef CONTROLLER_POLL_DEBOUNCE_EN
    // 3C was stable over two polls; alternating samples must not move the output.
    btn1 = 8'h01; run_poll("deb_a", 1'b0); check("deb_a_const", b1, 8'h3C);
    btn1 = 8'h02; run_poll("deb_b", 1'b0); check("deb_b_const", b1, 8'h3C);
    btn1 = 8'h01; run_poll("deb_c", 1'b0); check("deb_c_const", b1, 8'h3C);
    btn1 = 8'h02; run_poll("deb_d", 1'b0); check("deb_d_const", b1, 8'h3C);
    btn1 = 8'h02; run_poll("deb_e", 1'b0); check("deb_e_const", b1, 8'h02);
    check("deb_ctrl2_const", b2, 8'hC3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
